// File: rtl/slice_pkg.sv
// slice_pkg: shared geometry, FSM state encoding and the forward 5x5 slice
// permutation (pi) for the sponge-state slice datapath.
// Bit index inside a 25-bit slice is x + 5*y.
package slice_pkg;

  localparam int LANES   = 64;
  localparam int SLICE_W = 25;
  localparam int STATE_W = LANES * SLICE_W;
  localparam int CNT_W   = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Forward pi: decoded bit (x,y) lands on encoded bit (y, (2x+3y) mod 5).
  function automatic logic [SLICE_W-1:0] pi25_f(input logic [SLICE_W-1:0] d);
    logic [SLICE_W-1:0] e;
    e = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        e[y + 5 * ((2 * x + 3 * y) % 5)] = d[x + 5 * y];
      end
    end
    return e;
  endfunction

endpackage

// File: rtl/inv_pi25.sv
// inv_pi25: combinational inverse of the 25-bit slice permutation.
// Encoded bit (x',y') returns to decoded bit ((x'+3y') mod 5, x').
module inv_pi25
  import slice_pkg::*;
(
  input  logic [SLICE_W-1:0] enc,
  output logic [SLICE_W-1:0] dec
);

  // Pure wiring: every output bit is one input bit, no logic gates.
  always_comb begin
    dec = '0;
    for (int yp = 0; yp < 5; yp++) begin
      for (int xp = 0; xp < 5; xp++) begin
        dec[((xp + 3 * yp) % 5) + 5 * xp] = enc[xp + 5 * yp];
      end
    end
  end

endmodule

// File: rtl/slice_decoder.sv
// slice_decoder: restores a 1600-bit state from its slice-encoded form, one
// 25-bit slice per cycle, under a start/done handshake.
// Geometry (LANES, SLICE_W) comes from slice_pkg.
// Optional feature macro: SLICE_ROUNDTRIP_CHECK_EN adds the sticky err output
// that re-encodes every decoded slice and flags any disagreement.
//
// Handshake: start is a level sampled on the rising edge only while IDLE; a
// sampled start captures `in` at that edge. Anything on start in RUN or DONE
// is dropped, never queued. done is a single-cycle pulse in the DONE state;
// busy is high exactly while in RUN.
module slice_decoder
  import slice_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] in,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] out,
`ifdef SLICE_ROUNDTRIP_CHECK_EN
  output logic               err,
`endif
  output state_e             dbg_state
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] buf_q, buf_d;
  logic [STATE_W-1:0] out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SLICE_W-1:0] enc_slice;
  logic [SLICE_W-1:0] dec_slice;
  logic [LANES-1:0]   slice_we;
`ifdef SLICE_ROUNDTRIP_CHECK_EN
  logic               err_q, err_d;
`endif

  // Select the buffered slice addressed by cnt.
  always_comb begin
    enc_slice = '0;
    for (int i = 0; i < LANES; i++) begin
      if (cnt_q == CNT_W'(i)) enc_slice = buf_q[i * SLICE_W +: SLICE_W];
    end
  end

  inv_pi25 u_inv (
    .enc (enc_slice),
    .dec (dec_slice)
  );

  // One-hot slice write enable, only active while decoding.
  always_comb begin
    slice_we          = '0;
    slice_we[cnt_q]   = (state_q == RUN);
  end

  // Next-state, counter, buffer capture and out register bank.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    for (int i = 0; i < LANES; i++) begin
      if (slice_we[i]) out_d[i * SLICE_W +: SLICE_W] = dec_slice;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          buf_d   = in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(LANES - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

`ifdef SLICE_ROUNDTRIP_CHECK_EN
  // Sticky flag: re-encode the decoded slice and compare with its source.
  always_comb begin
    err_d = err_q;
    if ((state_q == RUN) && (pi25_f(dec_slice) != enc_slice)) err_d = 1'b1;
  end
`endif

  // State registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SLICE_ROUNDTRIP_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SLICE_ROUNDTRIP_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out       = out_q;
  assign dbg_state = state_q;
`ifdef SLICE_ROUNDTRIP_CHECK_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_slice_decoder.sv
// tb_slice_decoder: directed and randomized checks of slice_decoder against a
// coordinate-level model of the inverse permutation.
module tb_slice_decoder;
  import slice_pkg::*;

  logic               clk;
  logic               rst;
  logic               start;
  logic [STATE_W-1:0] in_v;
  logic               busy;
  logic               done;
  logic [STATE_W-1:0] out_v;
  state_e             dbg_state;
`ifdef SLICE_ROUNDTRIP_CHECK_EN
  logic               err;
`endif

  int errors = 0;
  int checks = 0;

  logic [STATE_W-1:0] exp_q[$];

  slice_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in        (in_v),
    .busy      (busy),
    .done      (done),
    .out       (out_v),
`ifdef SLICE_ROUNDTRIP_CHECK_EN
    .err       (err),
`endif
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each encoded bit (x',y') of every slice moves to
  // decoded bit ((x'+3y') mod 5, x') of the same slice.
  function automatic logic [STATE_W-1:0] model_decode(input logic [STATE_W-1:0] e);
    logic [STATE_W-1:0] d;
    d = '0;
    for (int s = 0; s < LANES; s++)
      for (int yp = 0; yp < 5; yp++)
        for (int xp = 0; xp < 5; xp++)
          d[s * 25 + ((xp + 3 * yp) % 5) + 5 * xp] = e[s * 25 + xp + 5 * yp];
    return d;
  endfunction

  function automatic logic [STATE_W-1:0] encode_state(input logic [STATE_W-1:0] d);
    logic [STATE_W-1:0] e;
    for (int s = 0; s < LANES; s++) e[s * 25 +: 25] = pi25_f(d[s * 25 +: 25]);
    return e;
  endfunction

  function automatic logic [STATE_W-1:0] rand_state();
    logic [STATE_W-1:0] v;
    v = '0;
    for (int i = 0; i < STATE_W / 32; i++) v[i * 32 +: 32] = $urandom();
    return v;
  endfunction

  // Scoreboard checks
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [STATE_W-1:0] obs,
                       input logic [STATE_W-1:0] exp);
    int fd;
    fd = -1;
    for (int i = 0; i < STATE_W; i++)
      if (fd < 0 && obs[i] !== exp[i]) fd = i;
    if (fd < 0) fd = 0;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: first differing bit %0d observed=%b expected=%b",
             tag, fd, obs[fd], exp[fd]);
    end
  endtask

  task automatic check_out(input string tag);
    logic [STATE_W-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk_w(tag, out_v, e);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for E0 and observe edges E0..E<len>; returns at E<len>+1.
  task automatic run_decode(input logic [STATE_W-1:0] v, input int len,
                            output int busy_n, output int done_n, output int done_at);
    in_v    = v;
    start   = 1'b1;
    step();
    start   = 1'b0;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    for (int k = 0; k <= len; k++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (k < len) step();
    end
  endtask

  initial begin
    logic [STATE_W-1:0] v, v2, e;
    int bn, dn, da;

    rst   = 1'b1;
    start = 1'b0;
    in_v  = rand_state();

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk_w("reset_out", out_v, '0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_state", int'(dbg_state), int'(IDLE));
`ifdef SLICE_ROUNDTRIP_CHECK_EN
    chk("reset_err", int'(err), 0);
`endif

    // Single bit in slice 0: encoded (2,0) -> decoded bit 12
    v = '0; v[2] = 1'b1;
    e = '0; e[12] = 1'b1;
    exp_q.push_back(e);
    run_decode(v, 66, bn, dn, da);
    check_out("slice0_bit");
    chk("slice0_done_count", dn, 1);
    chk("slice0_done_edge", da, 64);
    chk("slice0_state_idle", int'(dbg_state), int'(IDLE));

    // Single bit in slice 63: encoded (0,1) -> decoded bit 3 of slice 63
    v = '0; v[25 * 63 + 5] = 1'b1;
    e = '0; e[1578] = 1'b1;
    exp_q.push_back(e);
    run_decode(v, 66, bn, dn, da);
    check_out("slice63_bit");
    chk("slice63_busy_cycles", bn, 64);
    chk("slice63_done_count", dn, 1);

    // Round trip of random states through the forward map
    for (int r = 0; r < 3; r++) begin
      v = rand_state();
      exp_q.push_back(v);
      run_decode(encode_state(v), 66, bn, dn, da);
      check_out("roundtrip_random");
      chk("roundtrip_done_edge", da, 64);
    end

    // Random encoded input against the coordinate model
    v = rand_state();
    exp_q.push_back(model_decode(v));
    run_decode(v, 66, bn, dn, da);
    check_out("model_random");

    // All ones
    v = '1;
    exp_q.push_back(v);
    run_decode(v, 66, bn, dn, da);
    check_out("all_ones");
`ifdef SLICE_ROUNDTRIP_CHECK_EN
    chk("clean_runs_err", int'(err), 0);
`endif

    // Handshake: in changed after E5, start re-raised for E10..E65
    v  = rand_state();
    v2 = rand_state();
    exp_q.push_back(model_decode(v));
    in_v  = v;
    start = 1'b1;
    step();
    start = 1'b0;
    bn = 0; dn = 0; da = -1;
    for (int k = 0; k <= 70; k++) begin
      if (busy) bn++;
      if (done) begin
        dn++;
        if (da < 0) da = k;
      end
      if (k == 5) in_v = v2;
      start = (k >= 9 && k <= 64);
      if (k < 70) step();
    end
    start = 1'b0;
    check_out("in_change_ignored");
    chk("restart_ignored_done_count", dn, 1);
    chk("restart_ignored_done_edge", da, 64);
    chk("restart_ignored_busy_cycles", bn, 64);

    // Back-to-back: second start at the first edge seen in IDLE
    v  = rand_state();
    v2 = rand_state();
    run_decode(v, 64, bn, dn, da);
    chk("b2b_first_done", int'(done), 1);
    step();
    chk("b2b_idle_after_done", int'(dbg_state), int'(IDLE));
    exp_q.push_back(model_decode(v2));
    run_decode(v2, 66, bn, dn, da);
    check_out("b2b_second_out");
    chk("b2b_second_done_edge", da, 64);

    // Reset mid-run at E30
    v     = rand_state();
    in_v  = v;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 30; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_w("midrun_reset_out", out_v, '0);
    chk("midrun_reset_state", int'(dbg_state), int'(IDLE));
    chk("midrun_reset_busy", int'(busy), 0);
    dn = 0; bn = 0;
    for (int k = 0; k < 70; k++) begin
      if (done) dn++;
      if (busy) bn++;
      step();
    end
    chk("midrun_reset_no_done", dn, 0);
    chk("midrun_reset_no_busy", bn, 0);

`ifdef SLICE_ROUNDTRIP_CHECK_EN
    // Corrupt the decoded slice 7 for one cycle
    v = rand_state();
    v[7 * 25] = 1'b1;
    in_v  = v;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 7; k++) step();
    chk("err_before_fault", int'(err), 0);
    force dut.dec_slice = 25'h0;
    step();
    release dut.dec_slice;
    chk("err_at_e8", int'(err), 1);
    for (int k = 9; k <= 66; k++) step();
    chk("err_held_after_run", int'(err), 1);
    run_decode(encode_state(rand_state()), 66, bn, dn, da);
    chk("err_held_over_start", int'(err), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("err_cleared_by_rst", int'(err), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
